// File: rtl/can_cfg_sequencer.sv
// Bring-up sequencer for one CAN register port: enter reset mode, program and verify
// the timing registers, leave reset mode, wait for bus idle; arbitrates host access otherwise.
module can_cfg_sequencer #(
    parameter int unsigned BIT_TIME_CLKS = 200,
    parameter int unsigned IDLE_BITS     = 11,
    parameter int unsigned MODE_ADDR     = 0,
    parameter int unsigned BTR0_ADDR     = 6,
    parameter int unsigned BTR1_ADDR     = 7
) (
    input  logic        clk_i,
    input  logic        reg_rst_i,
    input  logic        cfg_start_i,
    input  logic [31:0] cfg_btr0_i,
    input  logic [31:0] cfg_btr1_i,
    input  logic [31:0] cfg_mode_i,
    output logic        cfg_busy_o,
    output logic        cfg_done_o,
    output logic        cfg_err_o,
    input  logic        host_we_i,
    input  logic        host_re_i,
    input  logic [7:0]  host_addr_write_i,
    input  logic [7:0]  host_addr_read_i,
    input  logic [31:0] host_data_i,
    output logic [31:0] host_data_o,
    output logic        host_ack_o,
    output logic        can_reg_we_o,
    output logic        can_reg_re_o,
    output logic [7:0]  can_reg_addr_write_o,
    output logic [7:0]  can_reg_addr_read_o,
    output logic [31:0] can_reg_data_o,
    input  logic [31:0] can_reg_data_i
);

    localparam int unsigned IdleCycles = IDLE_BITS * BIT_TIME_CLKS;
    localparam int unsigned CntW       = $clog2(IdleCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(IdleCycles - 1);

    typedef enum logic [3:0] {
        StIdle, StEnterRst, StWrBtr0, StWrBtr1, StRdBtr0, StChkBtr0, StRdBtr1,
        StChkBtr1, StExitRst, StWaitIdle, StDone, StHWr, StHRd, StHRdw
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            err_q, err_d;
    logic [31:0]     host_data_q;

    logic        we_d, re_d;
    logic [7:0]  addr_wr_d, addr_rd_d;
    logic [31:0] data_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (cfg_start_i) begin
                    state_d = StEnterRst;
                    err_d   = 1'b0;
                end else if (host_we_i) begin
                    state_d = StHWr;
                end else if (host_re_i) begin
                    state_d = StHRd;
                end
            end
            StEnterRst: state_d = StWrBtr0;
            StWrBtr0:   state_d = StWrBtr1;
            StWrBtr1:   state_d = StRdBtr0;
            StRdBtr0:   state_d = StChkBtr0;
            StChkBtr0: begin
                if (can_reg_data_i != cfg_btr0_i) err_d = 1'b1;
                state_d = StRdBtr1;
            end
            StRdBtr1:   state_d = StChkBtr1;
            StChkBtr1: begin
                if (can_reg_data_i != cfg_btr1_i) err_d = 1'b1;
                // On a failed readback the controller is left in reset mode.
                state_d = err_d ? StDone : StExitRst;
            end
            StExitRst:  state_d = StWaitIdle;
            StWaitIdle: begin
                if (cnt_q == CntLast) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone:     state_d = StIdle;
            StHWr:      state_d = StIdle;
            StHRd:      state_d = StHRdw;
            StHRdw:     state_d = StIdle;
            default:    state_d = StIdle;
        endcase
    end

    // Port strobes are decoded from the next state so the registered outputs line up
    // with the state that owns them.
    always_comb begin
        we_d      = 1'b0;
        re_d      = 1'b0;
        addr_wr_d = '0;
        addr_rd_d = '0;
        data_d    = '0;
        unique case (state_d)
            StEnterRst: begin
                we_d      = 1'b1;
                addr_wr_d = 8'(MODE_ADDR);
                data_d    = 32'h1;
            end
            StWrBtr0: begin
                we_d      = 1'b1;
                addr_wr_d = 8'(BTR0_ADDR);
                data_d    = cfg_btr0_i;
            end
            StWrBtr1: begin
                we_d      = 1'b1;
                addr_wr_d = 8'(BTR1_ADDR);
                data_d    = cfg_btr1_i;
            end
            StRdBtr0: begin
                re_d      = 1'b1;
                addr_rd_d = 8'(BTR0_ADDR);
            end
            StRdBtr1: begin
                re_d      = 1'b1;
                addr_rd_d = 8'(BTR1_ADDR);
            end
            StExitRst: begin
                we_d      = 1'b1;
                addr_wr_d = 8'(MODE_ADDR);
                data_d    = {cfg_mode_i[31:1], 1'b0};
            end
            StHWr: begin
                we_d      = 1'b1;
                addr_wr_d = host_addr_write_i;
                data_d    = host_data_i;
            end
            StHRd: begin
                re_d      = 1'b1;
                addr_rd_d = host_addr_read_i;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reg_rst_i) begin
        if (reg_rst_i) begin
            state_q              <= StIdle;
            cnt_q                <= '0;
            err_q                <= 1'b0;
            host_data_q          <= '0;
            can_reg_we_o         <= 1'b0;
            can_reg_re_o         <= 1'b0;
            can_reg_addr_write_o <= '0;
            can_reg_addr_read_o  <= '0;
            can_reg_data_o       <= '0;
        end else begin
            state_q              <= state_d;
            cnt_q                <= cnt_d;
            err_q                <= err_d;
            if (state_q == StHRdw) host_data_q <= can_reg_data_i;
            can_reg_we_o         <= we_d;
            can_reg_re_o         <= re_d;
            can_reg_addr_write_o <= addr_wr_d;
            can_reg_addr_read_o  <= addr_rd_d;
            can_reg_data_o       <= data_d;
        end
    end

    // Read data is valid while in StHRdw, so pass it through alongside the ack.
    assign host_data_o = (state_q == StHRdw) ? can_reg_data_i : host_data_q;
    assign host_ack_o  = (state_q == StHWr) || (state_q == StHRdw);
    assign cfg_done_o  = (state_q == StDone);
    assign cfg_err_o   = err_q;
    assign cfg_busy_o  = !((state_q == StIdle) || (state_q == StHWr) ||
                           (state_q == StHRd) || (state_q == StHRdw));

endmodule

// File: tb/tb_can_cfg_sequencer.sv
// Directed bench for can_cfg_sequencer with a small behavioural model of the CAN register port.
module tb_can_cfg_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_start;
    logic [31:0] cfg_btr0, cfg_btr1, cfg_mode;
    logic        cfg_busy, cfg_done, cfg_err;
    logic        host_we, host_re;
    logic [7:0]  host_addr_write, host_addr_read;
    logic [31:0] host_wdata, host_rdata;
    logic        host_ack;
    logic        can_we, can_re;
    logic [7:0]  can_addr_write, can_addr_read;
    logic [31:0] can_wdata, can_rdata;

    int checks = 0;
    int errors = 0;

    logic [31:0] mem [256];
    logic        corrupt = 1'b0;
    logic [39:0] wr_log[$];
    logic [7:0]  rd_log[$];

    always #5 clk = ~clk;

    can_cfg_sequencer dut (
        .clk_i                (clk),
        .reg_rst_i            (rst),
        .cfg_start_i          (cfg_start),
        .cfg_btr0_i           (cfg_btr0),
        .cfg_btr1_i           (cfg_btr1),
        .cfg_mode_i           (cfg_mode),
        .cfg_busy_o           (cfg_busy),
        .cfg_done_o           (cfg_done),
        .cfg_err_o            (cfg_err),
        .host_we_i            (host_we),
        .host_re_i            (host_re),
        .host_addr_write_i    (host_addr_write),
        .host_addr_read_i     (host_addr_read),
        .host_data_i          (host_wdata),
        .host_data_o          (host_rdata),
        .host_ack_o           (host_ack),
        .can_reg_we_o         (can_we),
        .can_reg_re_o         (can_re),
        .can_reg_addr_write_o (can_addr_write),
        .can_reg_addr_read_o  (can_addr_read),
        .can_reg_data_o       (can_wdata),
        .can_reg_data_i       (can_rdata)
    );

    // Register file model: read data appears the cycle after the read strobe.
    always @(posedge clk) begin
        if (can_we) begin
            mem[can_addr_write] <= can_wdata;
            wr_log.push_back({can_addr_write, can_wdata});
        end
        if (can_re) begin
            can_rdata <= mem[can_addr_read] ^ ((corrupt && can_addr_read == 8'd7) ? 32'h1 : 32'h0);
            rd_log.push_back(can_addr_read);
        end
    end

    task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Caller raises cfg_start; returns once done is seen or the budget runs out.
    task automatic wait_done(input string tag, input int exp_n, input int we_at);
        int n = 0;
        int seen = 0;
        while (n < 3000 && seen == 0) begin
            step();
            n++;
            if (n == 1) cfg_start = 1'b0;
            if (n == we_at) host_we = 1'b1;
            if (cfg_done) seen = n;
        end
        chk(tag, 40'(seen), 40'(exp_n));
    endtask

    task automatic clear_logs();
        wr_log.delete();
        rd_log.delete();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        can_rdata       = '0;
        rst             = 1'b1;
        cfg_start       = 1'b0;
        cfg_btr0        = 32'h00A9_D25D;
        cfg_btr1        = 32'h0002_A5DD;
        cfg_mode        = 32'h9;
        host_we         = 1'b0;
        host_re         = 1'b0;
        host_addr_write = 8'd4;
        host_addr_read  = 8'd6;
        host_wdata      = 32'h55;

        // Reset state
        repeat (3) step();
        chk("rst_outputs", {can_we, can_re, cfg_busy, cfg_done, cfg_err, host_ack},
            40'd0);
        chk("rst_hdata", 40'(host_rdata), 40'd0);
        @(negedge clk);
        rst = 1'b0;
        step();
        clear_logs();

        // Nominal sequence
        cfg_start = 1'b1;
        wait_done("t1_done_latency", 2209, 0);
        chk("t1_wr_count", 40'(wr_log.size()), 40'd4);
        if (wr_log.size() == 4) begin
            chk("t1_wr0", wr_log[0], {8'd0, 32'h1});
            chk("t1_wr1", wr_log[1], {8'd6, 32'h00A9_D25D});
            chk("t1_wr2", wr_log[2], {8'd7, 32'h0002_A5DD});
            chk("t1_wr3", wr_log[3], {8'd0, 32'h8});
        end
        chk("t1_rd_count", 40'(rd_log.size()), 40'd2);
        if (rd_log.size() == 2) chk("t1_rd_addrs", {rd_log[0], rd_log[1]}, {8'd6, 8'd7});
        chk("t1_err", 40'(cfg_err), 40'd0);
        chk("t1_busy_in_done", 40'(cfg_busy), 40'd1);
        step();
        chk("t1_idle_busy", 40'(cfg_busy), 40'd0);

        // Host read from IDLE
        clear_logs();
        host_re = 1'b1;
        step();
        chk("t4_re_strobe", {can_re, can_addr_read, host_ack}, {1'b1, 8'd6, 1'b0});
        step();
        chk("t4_ack_data", {host_ack, host_rdata}, {1'b1, 32'h00A9_D25D});
        host_re = 1'b0;
        step();
        chk("t4_hold", {host_ack, can_re, host_rdata}, {1'b0, 1'b0, 32'h00A9_D25D});

        // Host write raised during WAIT_IDLE waits for DONE
        clear_logs();
        cfg_start = 1'b1;
        wait_done("t3_done_latency", 2209, 20);
        chk("t3_no_early_host_wr", 40'(wr_log.size()), 40'd4);
        chk("t3_no_ack_busy", 40'(host_ack), 40'd0);
        step();
        chk("t3_idle_gap", {can_we, host_ack}, {1'b0, 1'b0});
        step();
        chk("t3_host_wr", {can_we, host_ack, can_addr_write, can_wdata},
            {1'b1, 1'b1, 8'd4, 32'h55});
        host_we = 1'b0;
        step();
        chk("t3_after", {can_we, host_ack}, {1'b0, 1'b0});

        // BTR1 readback mismatch
        clear_logs();
        corrupt   = 1'b1;
        cfg_start = 1'b1;
        wait_done("t2_done_latency", 8, 0);
        chk("t2_err", 40'(cfg_err), 40'd1);
        chk("t2_wr_count", 40'(wr_log.size()), 40'd3);
        if (wr_log.size() == 3) chk("t2_last_wr", wr_log[2], {8'd7, 32'h0002_A5DD});
        step();
        chk("t2_err_sticky", {cfg_err, cfg_busy}, {1'b1, 1'b0});

        // Start and host write in the same IDLE cycle
        clear_logs();
        cfg_start = 1'b1;
        host_we   = 1'b1;
        host_addr_write = 8'd3;
        host_wdata      = 32'hDEAD_BEEF;
        step();
        chk("t5_seq_first", {can_we, can_addr_write, can_wdata, host_ack},
            {1'b1, 8'd0, 32'h1, 1'b0});
        cfg_start = 1'b0;
        wait_done("t5_done_latency", 7, 0);
        step();
        chk("t5_idle_gap", {can_we, host_ack}, {1'b0, 1'b0});
        step();
        chk("t5_host_wr", {can_we, host_ack, can_addr_write, can_wdata},
            {1'b1, 1'b1, 8'd3, 32'hDEAD_BEEF});
        host_we = 1'b0;
        corrupt = 1'b0;
        step();

        // Reset during WR_BTR1 then a clean restart
        clear_logs();
        cfg_start = 1'b1;
        step();
        cfg_start = 1'b0;
        step();
        step();
        chk("t6_in_wr_btr1", {can_we, can_addr_write}, {1'b1, 8'd7});
        rst = 1'b1;
        #1;
        chk("t6_rst_outputs", {can_we, can_re, can_addr_write, can_wdata[15:0], cfg_busy},
            {1'b0, 1'b0, 8'd0, 16'd0, 1'b0});
        chk("t6_rst_err", {cfg_err, cfg_done, host_ack}, {1'b0, 1'b0, 1'b0});
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("t6_idle_after", {cfg_busy, can_we, can_re}, {1'b0, 1'b0, 1'b0});
        clear_logs();
        cfg_start = 1'b1;
        wait_done("t6_done_latency", 2209, 0);
        chk("t6_wr_count", 40'(wr_log.size()), 40'd4);
        if (wr_log.size() == 4) chk("t6_exit_wr", wr_log[3], {8'd0, 32'h8});
        chk("t6_err", 40'(cfg_err), 40'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/can_cfg_sequencer.md
Name: can_cfg_sequencer

Overview:
- Sits between the host register bus and one can_top_raw register port (reg_we/reg_re/addr/data).
- On request it runs the bring-up sequence in order:
  - enter reset mode;
  - write the nominal and FD bus timing registers (addr 6, 7);
  - read both back and verify them;
  - write the final mode value, which leaves reset mode;
  - wait 11 bit times for bus idle.
- While idle it arbitrates the register port to the host. The sequencer has priority.

Parameters:
- BIT_TIME_CLKS, 200, clk_i cycles per nominal bit (100 MHz / 500 kbit/s).
- IDLE_BITS, 11, bit times to wait after leaving reset mode.
- MODE_ADDR, 0, mode register address; bit 0 = reset mode.
- BTR0_ADDR, 6, nominal bus timing register address.
- BTR1_ADDR, 7, FD bus timing register address.

Ports:
- clk_i  in  1  system clock
- reg_rst_i  in  1  asynchronous active-high reset
- cfg_start_i  in  1  start sequence (sampled in IDLE only)
- cfg_btr0_i  in  32  nominal timing word
- cfg_btr1_i  in  32  FD timing word
- cfg_mode_i  in  32  final mode word; bit 0 forced to 0 when written
- cfg_busy_o  out  1  sequence in progress
- cfg_done_o  out  1  one-cycle pulse, sequence finished
- cfg_err_o  out  1  sticky readback mismatch
- host_we_i  in  1  host write request, held until host_ack_o
- host_re_i  in  1  host read request, held until host_ack_o
- host_addr_write_i  in  8  host write address
- host_addr_read_i  in  8  host read address
- host_data_i  in  32  host write data
- host_data_o  out  32  host read data
- host_ack_o  out  1  one-cycle transaction-complete pulse
- can_reg_we_o  out  1  to can_top_raw reg_we_i
- can_reg_re_o  out  1  to can_top_raw reg_re_i
- can_reg_addr_write_o  out  8  to reg_addr_write_i
- can_reg_addr_read_o  out  8  to reg_addr_read_i
- can_reg_data_o  out  32  to reg_data_in
- can_reg_data_i  in  32  from reg_data_out; valid the cycle after can_reg_re_o

Behaviour:
- Reset: all outputs 0, FSM = IDLE, idle counter 0, cfg_err_o cleared. Reset mid-operation aborts immediately. Nothing is replayed.
- All can_reg_* outputs are registered. Each strobe is exactly one cycle wide, and addr/data are valid in that cycle.
- FSM states: IDLE, ENTER_RST, WR_BTR0, WR_BTR1, RD_BTR0, CHK_BTR0, RD_BTR1, CHK_BTR1, EXIT_RST, WAIT_IDLE, DONE, H_WR, H_RD, H_RDW.
- IDLE: priority is cfg_start_i, then host_we_i, then host_re_i.
  - cfg_start_i: go to ENTER_RST and clear cfg_err_o.
  - host_we_i: go to H_WR.
  - host_re_i: go to H_RD.
- Action of each state:
  - ENTER_RST: we=1, addr=MODE_ADDR, data=32'h1.
  - WR_BTR0: we=1, addr=BTR0_ADDR, data=cfg_btr0_i.
  - WR_BTR1: we=1, addr=BTR1_ADDR, data=cfg_btr1_i.
  - RD_BTR0: re=1, addr_read=BTR0_ADDR.
  - CHK_BTR0: compare can_reg_data_i with cfg_btr0_i; mismatch sets cfg_err_o.
  - RD_BTR1 / CHK_BTR1: same as the BTR0 pair, for BTR1.
- After CHK_BTR1:
  - If cfg_err_o = 1, skip EXIT_RST and WAIT_IDLE and go to DONE. The controller stays in reset mode.
  - Otherwise go to EXIT_RST.
- EXIT_RST: we=1, addr=MODE_ADDR, data={cfg_mode_i[31:1],1'b0}.
- WAIT_IDLE:
  - Counter width is $clog2(IDLE_BITS*BIT_TIME_CLKS+1).
  - Counter counts 0..IDLE_BITS*BIT_TIME_CLKS-1, then goes to DONE. Default is 2200 cycles.
- DONE: cfg_done_o=1 for one cycle, then IDLE.
- cfg_busy_o is 1 in every state from ENTER_RST through DONE inclusive.
- Nominal sequence timing: start sampled at edge 0; ENTER_RST strobe in cycle 1; EXIT_RST in cycle 8; done pulse in cycle 9+2200.
- Config inputs must be held stable while cfg_busy_o = 1.
- Host write: H_WR drives we/addr/data from host_* and host_ack_o=1 in the same cycle, then IDLE.
- Host read:
  - H_RD drives re.
  - H_RDW captures can_reg_data_i into host_data_o and pulses host_ack_o, then IDLE.
  - host_data_o holds its value until the next read.
- Host request while busy: not acknowledged. The host keeps it asserted, and it is served after DONE returns to IDLE.
- host_we_i and host_re_i together: write first, read on the next IDLE visit.
- cfg_start_i while not in IDLE: ignored, with no queueing.

Test Plan:
1. Reset held, then released; pulse start with btr0=32'hA9D2_5D, btr1=32'h2A5_DD, mode=32'h9 → check:
   - writes (0,1), (6,btr0), (7,btr1), then (0,8);
   - reads of addr 6, 7;
   - done exactly 2209 cycles after start; cfg_err_o=0.
2. BTR1 readback forced to mismatch → cfg_err_o=1, no write of addr 0 with bit0=0, done pulses 8 cycles after start.
3. Host write (addr 4, 32'h55) during WAIT_IDLE → no can strobe until after done; then can_reg_we_o with addr 4 the cycle after IDLE, host_ack_o coincident.
4. Host read addr 6 from IDLE → re strobe, then host_data_o=btr0 with host_ack_o one cycle later.
5. cfg_start_i and host_we_i asserted in the same IDLE cycle → sequence runs first; host write acked after DONE.
6. reg_rst_i asserted during WR_BTR1 → all outputs 0 immediately; FSM IDLE after release; a new start completes normally.
